request_unit: RTL and testbench

REQUEST_UNIT -- requirements
Module: request_unit

---
 rtl/request_unit_if.sv | 34 +++
 rtl/request_unit.sv | 129 ++++++++++++
 tb/tb_request_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/request_unit_if.sv
// Bundle of decoder, datapath and memory-side signals around the request unit.
// master = the request unit itself, slave = the surrounding core/memory model.
interface request_unit_if #(
  parameter int CNT_W = 16
);
  logic             ihit;
  logic             dhit;
  logic             cu_dREN;
  logic             cu_dWEN;
  logic             cu_halt;
  logic [31:0]      alu_addr;
  logic [31:0]      store_data;
  logic             iREN;
  logic             dREN;
  logic             dWEN;
  logic [31:0]      dmemaddr;
  logic [31:0]      dmemstore;
  logic             pcEN;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    input  ihit, dhit, cu_dREN, cu_dWEN, cu_halt, alu_addr, store_data,
    output iREN, dREN, dWEN, dmemaddr, dmemstore, pcEN, halt,
           stall_cnt, retire_cnt
  );

  modport slave (
    output ihit, dhit, cu_dREN, cu_dWEN, cu_halt, alu_addr, store_data,
    input  iREN, dREN, dWEN, dmemaddr, dmemstore, pcEN, halt,
           stall_cnt, retire_cnt
  );
endinterface

// File: rtl/request_unit.sv
// Sequences instruction fetch against a single outstanding data access and
// keeps retire/stall statistics; halting freezes the unit until reset.
module request_unit #(
  parameter int CNT_W = 16
) (
  input  logic           CLK,
  input  logic           nRST,
  request_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q,     state_d;
  logic             dren_q,      dren_d;
  logic             dwen_q,      dwen_d;
  logic             halt_q,      halt_d;
  logic [31:0]      dmemaddr_q,  dmemaddr_d;
  logic [31:0]      dmemstore_q, dmemstore_d;
  logic [CNT_W-1:0] stall_q,     stall_d;
  logic [CNT_W-1:0] retire_q,    retire_d;
  logic             pcen;
  logic             mem_op;

  always_comb begin
    state_d     = state_q;
    dren_d      = dren_q;
    dwen_d      = dwen_q;
    halt_d      = halt_q;
    dmemaddr_d  = dmemaddr_q;
    dmemstore_d = dmemstore_q;
    stall_d     = stall_q;
    retire_d    = retire_q;
    pcen        = 1'b0;
    mem_op      = bus.cu_dREN | bus.cu_dWEN;

    case (state_q)
      IDLE: begin
        if (bus.ihit) begin
          if (bus.cu_halt) begin
            // halt outranks any memory op decoded in the same instruction
            state_d = HALTED;
            halt_d  = 1'b1;
          end else if (mem_op) begin
            state_d     = DATA;
            dmemaddr_d  = bus.alu_addr;
            dmemstore_d = bus.store_data;
            dwen_d      = bus.cu_dWEN;
            dren_d      = bus.cu_dREN & ~bus.cu_dWEN;
          end else begin
            pcen     = 1'b1;
            retire_d = retire_q + CNT_ONE;
          end
        end
      end

      DATA: begin
        if (bus.dhit) begin
          pcen     = 1'b1;
          retire_d = retire_q + CNT_ONE;
          dren_d   = 1'b0;
          dwen_d   = 1'b0;
          state_d  = IDLE;
        end else if (stall_q != CNT_MAX) begin
          stall_d = stall_q + CNT_ONE;
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = IDLE;
        dren_d  = 1'b0;
        dwen_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      dren_q      <= 1'b0;
      dwen_q      <= 1'b0;
      halt_q      <= 1'b0;
      dmemaddr_q  <= '0;
      dmemstore_q <= '0;
      stall_q     <= '0;
      retire_q    <= '0;
    end else begin
      state_q     <= state_d;
      dren_q      <= dren_d;
      dwen_q      <= dwen_d;
      halt_q      <= halt_d;
      dmemaddr_q  <= dmemaddr_d;
      dmemstore_q <= dmemstore_d;
      stall_q     <= stall_d;
      retire_q    <= retire_d;
    end
  end

  // pcEN is qualified by nRST so it drops the instant reset asserts
  assign bus.pcEN       = pcen & nRST;
  assign bus.iREN       = (state_q == IDLE);
  assign bus.dREN       = dren_q;
  assign bus.dWEN       = dwen_q;
  assign bus.halt       = halt_q;
  assign bus.dmemaddr   = dmemaddr_q;
  assign bus.dmemstore  = dmemstore_q;
  assign bus.stall_cnt  = stall_q;
  assign bus.retire_cnt = retire_q;

  a_pcen_has_hit: assert property (@(posedge CLK) disable iff (!nRST)
    bus.pcEN |-> (bus.ihit || bus.dhit));

  a_halt_absorbing: assert property (@(posedge CLK) disable iff (!nRST)
    (state_q == HALTED) |=> (state_q == HALTED));

  a_one_request: assert property (@(posedge CLK) disable iff (!nRST)
    !(dren_q && dwen_q));

endmodule

// File: tb/tb_request_unit.sv
// Randomised and directed check of request_unit against a transaction-level
// model of the fetch / single-outstanding-access / halt behaviour.
module tb_request_unit;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic nrst;
  int   tests;
  int   fails;

  request_unit_if #(.CNT_W(CNT_W)) bus ();

  request_unit #(.CNT_W(CNT_W)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: at most one outstanding access, plus a halted flag and counters.
  bit          m_halted;
  bit          m_pending;
  bit          m_is_write;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  int          m_stall;
  int          m_retire;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_halted = 0; m_pending = 0; m_is_write = 0;
      m_addr = 0; m_data = 0; m_stall = 0; m_retire = 0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (m_pending) begin
      if (bus.dhit) begin
        m_pending = 0;
        m_is_write = 0;
        m_retire = (m_retire + 1) % (CMAX + 1);
      end else begin
        m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      end
    end else if (bus.ihit) begin
      if (bus.cu_halt) m_halted = 1;
      else if (bus.cu_dREN || bus.cu_dWEN) begin
        m_pending  = 1;
        m_is_write = bus.cu_dWEN;
        m_addr     = bus.alu_addr;
        m_data     = bus.store_data;
      end else m_retire = (m_retire + 1) % (CMAX + 1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare, mid-cycle when inputs and outputs are settled.
  always @(negedge clk) begin
    logic exp_pcen;
    exp_pcen = nrst && !m_halted &&
               (m_pending ? bus.dhit
                          : (bus.ihit && !bus.cu_halt && !bus.cu_dREN && !bus.cu_dWEN));
    check("iREN",       32'(bus.iREN),       32'(!m_halted && !m_pending));
    check("dREN",       32'(bus.dREN),       32'(m_pending && !m_is_write));
    check("dWEN",       32'(bus.dWEN),       32'(m_pending && m_is_write));
    check("halt",       32'(bus.halt),       32'(m_halted));
    check("pcEN",       32'(bus.pcEN),       32'(exp_pcen));
    check("stall_cnt",  32'(bus.stall_cnt),  32'(m_stall));
    check("retire_cnt", 32'(bus.retire_cnt), 32'(m_retire));
    if (m_pending) begin
      check("dmemaddr",  bus.dmemaddr,  m_addr);
      check("dmemstore", bus.dmemstore, m_data);
    end
  end

  // Drive one cycle of inputs, then step to just after the next rising edge.
  task automatic cyc(input bit ih, input bit dh, input bit rd, input bit wr,
                     input bit hl, input logic [31:0] addr, input logic [31:0] sd);
    bus.ihit = ih; bus.dhit = dh; bus.cu_dREN = rd; bus.cu_dWEN = wr;
    bus.cu_halt = hl; bus.alu_addr = addr; bus.store_data = sd;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    nrst = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0;
    nrst = 1'b0;
    bus.ihit = 0; bus.dhit = 0; bus.cu_dREN = 0; bus.cu_dWEN = 0;
    bus.cu_halt = 0; bus.alu_addr = 0; bus.store_data = 0;
    #2;
    check("rst_iREN",   32'(bus.iREN), 32'd1);
    check("rst_pcEN",   32'(bus.pcEN), 32'd0);
    check("rst_addr",   bus.dmemaddr,  32'd0);
    do_reset();

    // ALU ops
    repeat (3) cyc(1, 0, 0, 0, 0, 32'h1, 32'h2);
    check("alu_retire", 32'(bus.retire_cnt), 32'd3);

    // Load with two stall cycles
    cyc(1, 0, 1, 0, 0, 32'h40, 32'h0);
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0);
    cyc(0, 0, 0, 0, 0, 32'h0, 32'h0);
    check("ld_dREN",  32'(bus.dREN),      32'd1);
    check("ld_addr",  bus.dmemaddr,       32'h40);
    check("ld_stall", 32'(bus.stall_cnt), 32'd2);
    cyc(0, 1, 0, 0, 0, 32'h0, 32'h0);
    check("ld_done",  32'(bus.dREN),      32'd0);
    check("ld_retire", 32'(bus.retire_cnt), 32'd4);

    // Store with both request bits set
    cyc(1, 0, 1, 1, 0, 32'h80, 32'hDEAD_BEEF);
    check("st_dWEN", 32'(bus.dWEN), 32'd1);
    check("st_dREN", 32'(bus.dREN), 32'd0);
    check("st_data", bus.dmemstore, 32'hDEAD_BEEF);
    cyc(0, 0, 0, 0, 0, 32'h1234, 32'h5);
    check("st_addr_hold", bus.dmemaddr, 32'h80);
    cyc(0, 1, 0, 0, 0, 32'h0, 32'h0);

    // Reset while a load is outstanding
    cyc(1, 0, 1, 0, 0, 32'h44, 32'h0);
    #2 nrst = 1'b0;
    #1;
    check("mid_dREN",   32'(bus.dREN),       32'd0);
    check("mid_iREN",   32'(bus.iREN),       32'd1);
    check("mid_retire", 32'(bus.retire_cnt), 32'd0);
    check("mid_stall",  32'(bus.stall_cnt),  32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // Halt outranks a store; absorbing afterwards
    cyc(1, 0, 0, 0, 0, 32'h0, 32'h0);
    cyc(1, 0, 0, 1, 1, 32'h90, 32'h9);
    check("h_halt", 32'(bus.halt), 32'd1);
    check("h_dWEN", 32'(bus.dWEN), 32'd0);
    check("h_iREN", 32'(bus.iREN), 32'd0);
    repeat (5) cyc(1, 1, 1, 0, 0, 32'h0, 32'h0);
    check("h_retire", 32'(bus.retire_cnt), 32'd1);
    nrst = 1'b0;
    #1 check("h_clear", 32'(bus.halt), 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // Stall saturation and retire wrap at CNT_W=4
    cyc(1, 0, 1, 0, 0, 32'h10, 32'h0);
    repeat (20) cyc(0, 0, 0, 0, 0, 32'h0, 32'h0);
    check("sat_stall", 32'(bus.stall_cnt), 32'd15);
    cyc(0, 1, 0, 0, 0, 32'h0, 32'h0);
    do_reset();
    repeat (17) cyc(1, 0, 0, 0, 0, 32'h0, 32'h0);
    check("wrap_retire", 32'(bus.retire_cnt), 32'd1);

    // Random traffic with occasional halts and asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      bit ih, dh, rd, wr, hl;
      ih = ($urandom_range(0, 3) != 0);
      dh = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 2) == 0);
      wr = ($urandom_range(0, 3) == 0);
      hl = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 59) == 0) begin
        bus.ihit = ih; bus.dhit = dh;
        #2 nrst = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
      end else begin
        cyc(ih, dh, rd, wr, hl, $urandom, $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
